datapath_responder: RTL and testbench
=====================================

Name: datapath_responder

Overview:
- Responder end of the start/instruction/finished/result datapath protocol used by the ant draw and update sequencers.
- Accepts one instruction per handshake and decodes the opcode: NOP, MEMREAD, MEMWRITE or DRAW.
- Executes the instruction against a synchronous game-state RAM or the VGA plot port, then returns a result and raises finished.
- Sits behind the sequencer arbiter; exactly one initiator drives it at a time.

Parameters:
OPC_W, 3, opcode field width
ADDR_W, 10, RAM address width
DATA_W, 16, RAM data width and result width
X_W, 8, x coordinate width
Y_W, 7, y coordinate width
COL_W, 3, colour width
INSTR_W, 29, instruction width = OPC_W+ADDR_W+DATA_W

Ports:
clock  in  1  system clock
resetn  in  1  reset, synchronous, active-low
start  in  1  request from initiator, sampled while finished=1
instruction  in  INSTR_W  instruction word
finished  out  1  1 = idle/result valid, 0 = busy
result  out  DATA_W  result of last instruction
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write strobe, one-cycle pulse
mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after address
vga_x  out  X_W  plot x
vga_y  out  Y_W  plot y
vga_colour  out  COL_W  plot colour
vga_plot  out  1  plot strobe, one-cycle pulse

Behaviour:
- Reset (resetn=0 at clock edge, any state, including mid-operation):
  - Outputs: finished=1, result=0, mem_addr=0, mem_wdata=0, mem_we=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0.
  - State returns to IDLE; any in-flight instruction is dropped with no strobe.
- Opcode field is instruction[OPC_W-1:0]:
  - 0 = NOP, 1 = MEMREAD, 2 = MEMWRITE, 3 = DRAW.
  - 4-7 are executed as NOP.
- MEMREAD / MEMWRITE field layout:
  - addr = instruction[OPC_W+ADDR_W-1:OPC_W].
  - wdata = instruction[INSTR_W-1:OPC_W+ADDR_W].
- DRAW field layout, packed upward from bit OPC_W:
  - x (X_W), then y (Y_W), then colour (COL_W), then plot_en (1 bit).
  - Bits above the plot_en bit are ignored.
- States: IDLE, EXEC, RD_WAIT, RD_CAP, DONE.
- IDLE:
  - finished=1.
  - On start=1 at edge E0: latch instruction into an internal register, finished<=0, go to EXEC.
  - Later changes on the instruction port do not affect execution.
- EXEC (edge E1):
  - MEMREAD: mem_addr<=addr, go to RD_WAIT.
  - MEMWRITE: mem_addr<=addr, mem_wdata<=wdata, mem_we<=1 for exactly one cycle, result<=wdata, go to DONE.
  - DRAW: vga_x/vga_y/vga_colour<=fields; vga_plot<=plot_en for exactly one cycle; result<=0; go to DONE.
  - NOP/unknown: result<=0, go to DONE.
- RD_WAIT (E2): go to RD_CAP.
- RD_CAP (E3): result<=mem_rdata, go to DONE.
- DONE:
  - If start=0: finished<=1, go to IDLE.
  - Otherwise hold finished=0 until start falls.
  - This stops a held or repeated start from retriggering; each instruction requires start to go low before the next one is accepted.
- Latency from the edge sampling start to finished=1, with start already low:
  - MEMREAD: 4 cycles.
  - MEMWRITE, DRAW, NOP: 2 cycles.
- Register holds:
  - result holds its value from completion until the next instruction's result update.
  - vga_x/vga_y/vga_colour and mem_addr/mem_wdata hold their last values between strobes.
- Behaviour when start=1 and DONE occur in the same cycle is covered by the DONE rule: completion is deferred.
- start is ignored in every state except IDLE and DONE.

Test Plan:
- Reset, then write: MEMWRITE addr=0x005, data=0x0042, start high 2 cycles -> one mem_we pulse with addr 0x005/data 0x0042; result=0x0042; finished falls at E0 and rises 2 cycles later.
- Read-back: MEMREAD addr=0x005, RAM model returns 0x0042 -> result=0x0042; finished=1 exactly 4 cycles after the start edge; mem_we stays 0.
- DRAW x=17, y=33, colour=3'b101, plot_en=1 -> single vga_plot pulse with those values. Same instruction with plot_en=0 -> no pulse, finished still returns; result=0.
- Start held high for 10 cycles on a MEMWRITE -> exactly one mem_we pulse; finished stays 0 until the cycle after start falls.
- resetn pulsed low during RD_WAIT -> finished=1, result=0, no further strobes; the next MEMREAD executes normally.
- Opcode 6 -> no RAM or VGA activity; result=0; finished returns after 2 cycles.

Source files
------------

// File: rtl/datapath_responder_if.sv
// Bundle between the sequencer side, the responder, the game-state RAM and
// the VGA plot port.
//   start/instruction/finished/result : initiator handshake
//   mem_addr/mem_wdata/mem_we/mem_rdata : synchronous RAM port
//   vga_x/vga_y/vga_colour/vga_plot : plot port
// slave = responder view, master = environment (initiator + RAM + VGA) view.
interface datapath_responder_if #(
  parameter int unsigned INSTR_W = 29,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned X_W     = 8,
  parameter int unsigned Y_W     = 7,
  parameter int unsigned COL_W   = 3
);
  logic               start;
  logic [INSTR_W-1:0] instruction;
  logic               finished;
  logic [DATA_W-1:0]  result;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_rdata;
  logic [X_W-1:0]     vga_x;
  logic [Y_W-1:0]     vga_y;
  logic [COL_W-1:0]   vga_colour;
  logic               vga_plot;

  modport slave (
    input  start, instruction, mem_rdata,
    output finished, result, mem_addr, mem_wdata, mem_we,
           vga_x, vga_y, vga_colour, vga_plot
  );

  modport master (
    output start, instruction, mem_rdata,
    input  finished, result, mem_addr, mem_wdata, mem_we,
           vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/datapath_responder.sv
// Responder end of the start/instruction/finished/result datapath protocol.
// Latches one instruction per handshake, executes NOP / MEMREAD / MEMWRITE /
// DRAW against the game-state RAM or VGA plot port, returns a result and
// raises finished. A new instruction needs start to drop first.
// Ports:
//   clock  : system clock
//   resetn : synchronous, active-low reset
//   bus    : datapath_responder_if.slave (handshake, RAM port, plot port)
module datapath_responder #(
  parameter int unsigned OPC_W   = 3,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned X_W     = 8,
  parameter int unsigned Y_W     = 7,
  parameter int unsigned COL_W   = 3,
  parameter int unsigned INSTR_W = OPC_W + ADDR_W + DATA_W
) (
  input logic                  clock,
  input logic                  resetn,
  datapath_responder_if.slave  bus
);

  // Field offsets inside the instruction word
  localparam int unsigned ADDR_LO = OPC_W;
  localparam int unsigned DATA_LO = OPC_W + ADDR_W;
  localparam int unsigned X_LO    = OPC_W;
  localparam int unsigned Y_LO    = X_LO + X_W;
  localparam int unsigned COL_LO  = Y_LO + Y_W;
  localparam int unsigned PEN_BIT = COL_LO + COL_W;

  localparam logic [OPC_W-1:0] OP_MEMREAD  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_MEMWRITE = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_DRAW     = OPC_W'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_RD_WAIT,
    S_RD_CAP,
    S_DONE
  } state_t;

  state_t              state, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                finished_q, finished_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [X_W-1:0]      vga_x_q, vga_x_d;
  logic [Y_W-1:0]      vga_y_q, vga_y_d;
  logic [COL_W-1:0]    vga_colour_q, vga_colour_d;
  logic                vga_plot_q, vga_plot_d;

  // Decoded fields of the latched instruction
  logic [OPC_W-1:0]  opc;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_wdata;
  logic [X_W-1:0]    f_x;
  logic [Y_W-1:0]    f_y;
  logic [COL_W-1:0]  f_colour;
  logic              f_plot_en;

  assign opc       = instr_q[OPC_W-1:0];
  assign f_addr    = instr_q[ADDR_LO +: ADDR_W];
  assign f_wdata   = instr_q[DATA_LO +: DATA_W];
  assign f_x       = instr_q[X_LO +: X_W];
  assign f_y       = instr_q[Y_LO +: Y_W];
  assign f_colour  = instr_q[COL_LO +: COL_W];
  assign f_plot_en = instr_q[PEN_BIT];

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= S_IDLE;
      instr_q      <= INSTR_W'(0);
      finished_q   <= 1'b1;
      result_q     <= DATA_W'(0);
      mem_addr_q   <= ADDR_W'(0);
      mem_wdata_q  <= DATA_W'(0);
      mem_we_q     <= 1'b0;
      vga_x_q      <= X_W'(0);
      vga_y_q      <= Y_W'(0);
      vga_colour_q <= COL_W'(0);
      vga_plot_q   <= 1'b0;
    end else begin
      state        <= state_d;
      instr_q      <= instr_d;
      finished_q   <= finished_d;
      result_q     <= result_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  // Next state and next register values; strobes default low, the rest hold
  always_comb begin
    state_d      = state;
    instr_d      = instr_q;
    finished_d   = finished_q;
    result_d     = result_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          instr_d    = bus.instruction;
          finished_d = 1'b0;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        case (opc)
          OP_MEMREAD: begin
            mem_addr_d = f_addr;
            state_d    = S_RD_WAIT;
          end
          OP_MEMWRITE: begin
            mem_addr_d  = f_addr;
            mem_wdata_d = f_wdata;
            mem_we_d    = 1'b1;
            result_d    = f_wdata;
          end
          OP_DRAW: begin
            vga_x_d      = f_x;
            vga_y_d      = f_y;
            vga_colour_d = f_colour;
            vga_plot_d   = f_plot_en;
            result_d     = DATA_W'(0);
          end
          default: result_d = DATA_W'(0);
        endcase
      end
      // RAM data becomes valid one cycle after the address is registered
      S_RD_WAIT: state_d = S_RD_CAP;
      S_RD_CAP: begin
        result_d = bus.mem_rdata;
        state_d  = S_DONE;
      end
      // Completion waits for start to drop so a held start cannot retrigger
      S_DONE: begin
        if (!bus.start) begin
          finished_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.finished   = finished_q;
  assign bus.result     = result_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_datapath_responder.sv
// Self-checking bench for datapath_responder: directed scenarios plus
// randomized instructions checked against a transaction-level model.
module tb_datapath_responder;

  localparam int unsigned INSTR_W = 29;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 10;

  logic clock;
  logic resetn;

  datapath_responder_if bus ();

  datapath_responder dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAM the DUT talks to
  logic [DATA_W-1:0] ram     [1024];
  // Expected RAM contents, maintained by the reference model
  logic [DATA_W-1:0] ref_mem [1024];

  always @(posedge clock) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Strobe monitor: cumulative pulse counts and the values seen on them
  int unsigned       we_cnt = 0;
  int unsigned       plot_cnt = 0;
  logic [ADDR_W-1:0] we_addr;
  logic [DATA_W-1:0] we_data;
  logic [7:0]        pl_x;
  logic [6:0]        pl_y;
  logic [2:0]        pl_col;

  always @(negedge clock) begin
    if (bus.mem_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= bus.mem_addr;
      we_data <= bus.mem_wdata;
    end
    if (bus.vga_plot) begin
      plot_cnt <= plot_cnt + 1;
      pl_x     <= bus.vga_x;
      pl_y     <= bus.vga_y;
      pl_col   <= bus.vga_colour;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk_mem(input logic [2:0] op, input logic [9:0] addr,
                                                input logic [15:0] data);
    return {data, addr, op};
  endfunction

  function automatic logic [INSTR_W-1:0] mk_draw(input logic [7:0] x, input logic [6:0] y,
                                                 input logic [2:0] col, input logic en,
                                                 input logic [6:0] junk);
    return {junk, en, col, y, x, 3'd3};
  endfunction

  // Issue one instruction with start held for 'hold' cycles (>=1) and check
  // the outcome against the protocol rules.
  task automatic run_txn(input string tag, input logic [INSTR_W-1:0] instr, input int hold);
    logic [2:0]  op;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  col;
    logic        en;
    int          lat, edges;
    logic [15:0] exp_res;
    int unsigned exp_we, exp_plot, we0, plot0;

    op    = instr[2:0];
    addr  = instr[12:3];
    wdata = instr[28:13];
    x     = instr[10:3];
    y     = instr[17:11];
    col   = instr[20:18];
    en    = instr[21];
    exp_we = 0; exp_plot = 0; exp_res = 16'h0; lat = 2;
    case (op)
      3'd1: begin lat = 4; exp_res = ref_mem[addr]; end
      3'd2: begin exp_res = wdata; exp_we = 1; ref_mem[addr] = wdata; end
      3'd3: exp_plot = {31'd0, en};
      default: ;
    endcase
    if (hold > lat) lat = hold;

    we0 = we_cnt; plot0 = plot_cnt;
    @(negedge clock);
    bus.instruction = instr;
    bus.start       = 1'b1;
    @(posedge clock);
    #1;
    check_eq({tag, "/fin_fall"}, 32'(bus.finished), 32'd0);
    // Scrambling the port must not affect the latched instruction
    bus.instruction = INSTR_W'($urandom);
    edges = 0;
    do begin
      if (edges + 1 >= hold) bus.start = 1'b0;
      @(posedge clock);
      edges++;
      #1;
    end while (!bus.finished && edges < 30);
    check_eq({tag, "/latency"}, 32'(edges), 32'(lat));
    check_eq({tag, "/result"}, 32'(bus.result), 32'(exp_res));
    @(negedge clock);
    check_eq({tag, "/we_cnt"}, we_cnt - we0, exp_we);
    check_eq({tag, "/plot_cnt"}, plot_cnt - plot0, exp_plot);
    if (exp_we != 0) begin
      check_eq({tag, "/we_addr"}, 32'(we_addr), 32'(addr));
      check_eq({tag, "/we_data"}, 32'(we_data), 32'(wdata));
    end
    if (exp_plot != 0) begin
      check_eq({tag, "/plot_x"}, 32'(pl_x), 32'(x));
      check_eq({tag, "/plot_y"}, 32'(pl_y), 32'(y));
      check_eq({tag, "/plot_col"}, 32'(pl_col), 32'(col));
    end
  endtask

  initial begin
    logic [INSTR_W-1:0] instr;
    logic [2:0]         op;
    int unsigned        we0, plot0;

    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 16'h0;
      ref_mem[i] = 16'h0;
    end
    resetn          = 1'b0;
    bus.start       = 1'b0;
    bus.instruction = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst/finished", 32'(bus.finished), 32'd1);
    check_eq("rst/result", 32'(bus.result), 32'd0);
    check_eq("rst/mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst/mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check_eq("rst/mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst/vga_x", 32'(bus.vga_x), 32'd0);
    check_eq("rst/vga_y", 32'(bus.vga_y), 32'd0);
    check_eq("rst/vga_colour", 32'(bus.vga_colour), 32'd0);
    check_eq("rst/vga_plot", 32'(bus.vga_plot), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    // Directed scenarios
    run_txn("wr", mk_mem(3'd2, 10'h005, 16'h0042), 2);
    run_txn("rd", mk_mem(3'd1, 10'h005, 16'hBEEF), 1);
    run_txn("draw_on", mk_draw(8'd17, 7'd33, 3'b101, 1'b1, 7'h55), 1);
    run_txn("draw_off", mk_draw(8'd17, 7'd33, 3'b101, 1'b0, 7'h2A), 1);
    run_txn("wr_hold", mk_mem(3'd2, 10'h3FF, 16'hA5C3), 10);
    run_txn("rd_max", mk_mem(3'd1, 10'h3FF, 16'h0000), 1);
    run_txn("op6", mk_mem(3'd6, 10'h005, 16'h1234), 1);
    run_txn("rd_hold", mk_mem(3'd1, 10'h005, 16'h0000), 7);

    // Reset while the read is waiting on RAM data
    we0 = we_cnt; plot0 = plot_cnt;
    @(negedge clock);
    bus.instruction = mk_mem(3'd1, 10'h005, 16'h0);
    bus.start       = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1 resetn = 1'b1;
    check_eq("midrst/finished", 32'(bus.finished), 32'd1);
    check_eq("midrst/result", 32'(bus.result), 32'd0);
    check_eq("midrst/mem_addr", 32'(bus.mem_addr), 32'd0);
    repeat (5) @(posedge clock);
    #1;
    check_eq("midrst/finished_idle", 32'(bus.finished), 32'd1);
    check_eq("midrst/result_idle", 32'(bus.result), 32'd0);
    check_eq("midrst/we_cnt", we_cnt - we0, 32'd0);
    check_eq("midrst/plot_cnt", plot_cnt - plot0, 32'd0);
    run_txn("rd_after_rst", mk_mem(3'd1, 10'h005, 16'h0), 1);

    // Randomized instructions over a small address window so reads hit writes
    for (int i = 0; i < 40; i++) begin
      op    = 3'($urandom_range(0, 7));
      instr = INSTR_W'($urandom);
      instr[2:0] = op;
      if (op == 3'd1 || op == 3'd2) instr[12:3] = 10'($urandom_range(0, 7));
      run_txn($sformatf("rnd%0d", i), instr, int'($urandom_range(1, 6)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
